// File: rtl/banked_mem_stage_pkg.sv
// rtl/banked_mem_stage_pkg.sv - shared encodings, arbiter states and address split helpers for banked_mem_stage
package mem_pkg;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // IDLE: starve count 0, DEFER: port B has lost at least once, FORCE: port B wins next conflict
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_DEFER,
        ARB_FORCE
    } arb_state_e;

    // Bank is the top bw bits of an aw-bit word address
    function automatic logic [31:0] bank_of(input logic [31:0] waddr, input int aw, input int bw);
        return waddr >> (aw - bw);
    endfunction

    // In-bank index is whatever remains below the bank bits
    function automatic logic [31:0] index_of(input logic [31:0] waddr, input int aw, input int bw);
        return waddr & ((32'd1 << (aw - bw)) - 32'd1);
    endfunction

endpackage

// File: rtl/banked_mem_stage_if.sv
// rtl/banked_mem_stage_if.sv - core EXMEM/MEMWB and port B signal bundle for banked_mem_stage
interface banked_mem_stage_if #(
    parameter int SIZE    = 256,
    parameter int NUM_COL = 4,
    parameter int WIDTH   = 32
);
    localparam int BAW = $clog2(SIZE) + 2;

    logic [31:0]        ALU_out_EXMEM;
    logic [2:0]         funct3_EXMEM;
    logic               mem_rd_en_EXMEM;
    logic               mem_wr_en_EXMEM;
    logic [WIDTH-1:0]   rs2_data_EXMEM;
    logic               reg_wr_en_EXMEM;
    logic [1:0]         reg_wr_ctrl_EXMEM;
    logic [4:0]         rd_EXMEM;
    logic [31:0]        pc_4_EXMEM;
    logic               stall_MEM;
    logic [WIDTH-1:0]   ld_data_MEMWB;
    logic               reg_wr_en_MEMWB;
    logic [1:0]         reg_wr_ctrl_MEMWB;
    logic [4:0]         rd_MEMWB;
    logic [31:0]        pc_4_MEMWB;
    logic [31:0]        ALU_out_MEMWB;
    logic               fault_MEMWB;
    logic               b_req;
    logic [BAW-1:0]     b_addr;
    logic [NUM_COL-1:0] b_we;
    logic [WIDTH-1:0]   b_wdata;
    logic               b_ack;
    logic               b_rvalid;
    logic [WIDTH-1:0]   b_rdata;

    modport master (
        output ALU_out_EXMEM, funct3_EXMEM, mem_rd_en_EXMEM, mem_wr_en_EXMEM, rs2_data_EXMEM,
               reg_wr_en_EXMEM, reg_wr_ctrl_EXMEM, rd_EXMEM, pc_4_EXMEM,
               b_req, b_addr, b_we, b_wdata,
        input  stall_MEM, ld_data_MEMWB, reg_wr_en_MEMWB, reg_wr_ctrl_MEMWB, rd_MEMWB,
               pc_4_MEMWB, ALU_out_MEMWB, fault_MEMWB, b_ack, b_rvalid, b_rdata
    );

    modport slave (
        input  ALU_out_EXMEM, funct3_EXMEM, mem_rd_en_EXMEM, mem_wr_en_EXMEM, rs2_data_EXMEM,
               reg_wr_en_EXMEM, reg_wr_ctrl_EXMEM, rd_EXMEM, pc_4_EXMEM,
               b_req, b_addr, b_we, b_wdata,
        output stall_MEM, ld_data_MEMWB, reg_wr_en_MEMWB, reg_wr_ctrl_MEMWB, rd_MEMWB,
               pc_4_MEMWB, ALU_out_MEMWB, fault_MEMWB, b_ack, b_rvalid, b_rdata
    );

endinterface

// File: rtl/bank_ram.sv
// rtl/bank_ram.sv - true dual-port RAM bank with byte write enables and registered read
module bank_ram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int NUM_COL   = 4,
    parameter int COL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en_a,
    input  logic [NUM_COL-1:0]       we_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         din_a,
    output logic [WIDTH-1:0]         dout_a,
    input  logic                     en_b,
    input  logic [NUM_COL-1:0]       we_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [WIDTH-1:0]         din_b,
    output logic [WIDTH-1:0]         dout_b
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_a_q, dout_b_q;

    // Both ports share one process so every lane has a single driver; the arbiter never lets both write one word
    always_ff @(posedge clk) begin
        if (en_a) begin
            dout_a_q <= mem_q[addr_a];
            for (int c = 0; c < NUM_COL; c++) begin
                if (we_a[c]) mem_q[addr_a][c*COL_WIDTH +: COL_WIDTH] <= din_a[c*COL_WIDTH +: COL_WIDTH];
            end
        end
        if (en_b) begin
            dout_b_q <= mem_q[addr_b];
            for (int c = 0; c < NUM_COL; c++) begin
                if (we_b[c]) mem_q[addr_b][c*COL_WIDTH +: COL_WIDTH] <= din_b[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule

// File: rtl/banked_mem_stage.sv
// rtl/banked_mem_stage.sv - banked MEM stage arbitrating core and port B (MEM_MISALIGN_TRAP_EN enables misalign faults)
module banked_mem_stage
    import mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 256,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    banked_mem_stage_if.slave bus
);
    localparam int AW    = $clog2(SIZE);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int IW    = AW - BW;
    localparam int DEPTH = SIZE / NUM_BANKS;

    logic [AW-1:0] core_word, b_word;
    logic [BW-1:0] bank_a, bank_b, ld_bank_q, b_bank_q;
    logic [IW-1:0] idx_a, idx_b;
    logic [1:0]    off, off_eff, ld_off_q;
    logic [2:0]    ld_f3_q;
    logic          trap, core_act, conflict, core_ex, stall, ack;
    logic [NUM_COL-1:0] st_we;
    logic [WIDTH-1:0]   st_data, ld_word, ld_shift, ld_data;
    logic [WIDTH-1:0]   dout_a [NUM_BANKS];
    logic [WIDTH-1:0]   dout_b [NUM_BANKS];
    arb_state_e    state_q, state_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          reg_wr_en_q, fault_q, ld_valid_q, b_rvalid_q;
    logic [1:0]    reg_wr_ctrl_q;
    logic [4:0]    rd_q;
    logic [31:0]   pc_4_q, alu_q;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.b_addr[1:0];
    assign core_word = bus.ALU_out_EXMEM[AW+1:2];
    assign b_word    = bus.b_addr[AW+1:2];
    assign bank_a    = BW'(bank_of(32'(core_word), AW, BW));
    assign bank_b    = BW'(bank_of(32'(b_word), AW, BW));
    assign idx_a     = IW'(index_of(32'(core_word), AW, BW));
    assign idx_b     = IW'(index_of(32'(b_word), AW, BW));
    assign off       = bus.ALU_out_EXMEM[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap    = ((bus.funct3_EXMEM[1:0] == 2'b01) && off[0]) ||
                     ((bus.funct3_EXMEM[1:0] == 2'b10) && (off != 2'b00));
    assign off_eff = off;
`else
    // Without the trap, low offset bits that break alignment are simply dropped
    assign trap    = 1'b0;
    assign off_eff = (bus.funct3_EXMEM[1:0] == 2'b10) ? 2'b00 :
                     (bus.funct3_EXMEM[1:0] == 2'b01) ? {off[1], 1'b0} : off;
`endif

    // Lane enables and lane-replicated store data; the enable picks which copy lands
    always_comb begin
        st_we   = '1;
        st_data = bus.rs2_data_EXMEM;
        case (bus.funct3_EXMEM)
            F3_SB: begin
                st_we   = 4'b0001 << off_eff;
                st_data = {4{bus.rs2_data_EXMEM[7:0]}};
            end
            F3_SH: begin
                st_we   = 4'b0011 << off_eff;
                st_data = {2{bus.rs2_data_EXMEM[15:0]}};
            end
            default: ;
        endcase
    end

    assign core_act = bus.mem_rd_en_EXMEM | bus.mem_wr_en_EXMEM;
    assign conflict = core_act && bus.b_req && (bank_a == bank_b) && (idx_a == idx_b) &&
                      (bus.mem_wr_en_EXMEM || (|bus.b_we));

    // Arbiter state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Arbiter next state, port B grant and the single forced stall of an episode
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        stall        = 1'b0;
        ack          = 1'b0;
        if (reset) begin
            stall = conflict && (state_q == ARB_FORCE);
            ack   = bus.b_req && (!conflict || (state_q == ARB_FORCE));
            if (ack || !bus.b_req) begin
                state_d      = ARB_IDLE;
                starve_cnt_d = '0;
            end else if (conflict) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
                state_d      = (starve_cnt_d == 4'(STARVE_MAX)) ? ARB_FORCE : ARB_DEFER;
            end
        end
    end

    assign core_ex       = reset && core_act && !stall;
    assign bus.stall_MEM = stall;
    assign bus.b_ack     = ack;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_ram #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH)
        ) u_ram (
            .clk    (clk),
            .en_a   (core_ex && (bank_a == BW'(g))),
            .we_a   ((bus.mem_wr_en_EXMEM && !trap) ? st_we : '0),
            .addr_a (idx_a),
            .din_a  (st_data),
            .dout_a (dout_a[g]),
            .en_b   (ack && (bank_b == BW'(g))),
            .we_b   (bus.b_we),
            .addr_b (idx_b),
            .din_b  (bus.b_wdata),
            .dout_b (dout_b[g])
        );
    end

    // MEMWB pipeline register; a forced stall turns into a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_wr_en_q   <= 1'b0;
            reg_wr_ctrl_q <= '0;
            rd_q          <= '0;
            pc_4_q        <= '0;
            alu_q         <= '0;
            fault_q       <= 1'b0;
            ld_valid_q    <= 1'b0;
            ld_f3_q       <= '0;
            ld_off_q      <= '0;
            ld_bank_q     <= '0;
            b_rvalid_q    <= 1'b0;
            b_bank_q      <= '0;
        end else begin
            reg_wr_en_q   <= bus.reg_wr_en_EXMEM && !stall;
            reg_wr_ctrl_q <= bus.reg_wr_ctrl_EXMEM;
            rd_q          <= bus.rd_EXMEM;
            pc_4_q        <= bus.pc_4_EXMEM;
            alu_q         <= bus.ALU_out_EXMEM;
            fault_q       <= core_ex && trap;
            ld_valid_q    <= core_ex && bus.mem_rd_en_EXMEM && !trap;
            ld_f3_q       <= bus.funct3_EXMEM;
            ld_off_q      <= off_eff;
            ld_bank_q     <= bank_a;
            b_rvalid_q    <= ack && (bus.b_we == '0);
            b_bank_q      <= bank_b;
        end
    end

    // Align and extend the registered bank word for the load that was issued last cycle
    always_comb begin
        ld_word  = dout_a[ld_bank_q];
        ld_shift = ld_word >> {ld_off_q, 3'b000};
        ld_data  = '0;
        if (ld_valid_q) begin
            case (ld_f3_q)
                F3_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
                F3_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
                F3_LBU:  ld_data = {24'd0, ld_shift[7:0]};
                F3_LHU:  ld_data = {16'd0, ld_shift[15:0]};
                default: ld_data = ld_word;
            endcase
        end
    end

    assign bus.ld_data_MEMWB     = ld_data;
    assign bus.reg_wr_en_MEMWB   = reg_wr_en_q;
    assign bus.reg_wr_ctrl_MEMWB = reg_wr_ctrl_q;
    assign bus.rd_MEMWB          = rd_q;
    assign bus.pc_4_MEMWB        = pc_4_q;
    assign bus.ALU_out_MEMWB     = alu_q;
    assign bus.fault_MEMWB       = fault_q;
    assign bus.b_rvalid          = b_rvalid_q;
    assign bus.b_rdata           = b_rvalid_q ? dout_b[b_bank_q] : '0;

endmodule

// File: doc/banked_mem_stage.md
BANKED_MEM_STAGE -- requirements
Module: banked_mem_stage

Interface
REQ-001 Parameters SHALL be: WIDTH 32 (word bits); SIZE 256 (total words, power of 2); NUM_BANKS 4 (power of 2, 2..16); NUM_COL 4 (byte lanes); COL_WIDTH 8 (lane bits); STARVE_MAX 4 (maximum consecutive deferrals of port B, 1..15).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk in 1: the single clock.
- reset in 1: asynchronous, active-low reset.
- ALU_out_EXMEM in 32: core byte address.
- funct3_EXMEM in 3: access size and sign.
- mem_rd_en_EXMEM in 1: load.
- mem_wr_en_EXMEM in 1: store.
- rs2_data_EXMEM in 32: store data.
- reg_wr_en_EXMEM in 1, reg_wr_ctrl_EXMEM in 2, rd_EXMEM in 5, pc_4_EXMEM in 32: WB passthrough.
- stall_MEM out 1: core must hold EXMEM this cycle.
- ld_data_MEMWB out 32: aligned and extended load result.
- reg_wr_en_MEMWB out 1, reg_wr_ctrl_MEMWB out 2, rd_MEMWB out 5, pc_4_MEMWB out 32, ALU_out_MEMWB out 32: registered passthrough.
- fault_MEMWB out 1: misaligned access flag.
- b_req in 1, b_addr in log2(SIZE)+2, b_we in NUM_COL, b_wdata in 32: PS/AXI request.
- b_ack out 1: request accepted pulse.
- b_rvalid out 1, b_rdata out 32: port B read return.

Function
REQ-003 Bank index SHALL be word address top log2(NUM_BANKS) bits; in-bank index SHALL be the remaining low word bits; both ports SHALL decode identically.
REQ-004 Store lane enables and data shift SHALL follow SB/SH/SW by byte offset; stores SHALL write only the selected bank.
REQ-005 Bank reads SHALL have 1-cycle latency; ld_data_MEMWB SHALL be valid in the cycle the *_MEMWB registers update, selected by registered bank index, shifted by registered offset, sign/zero-extended per LB/LH/LW/LBU/LHU.
REQ-006 A conflict SHALL be: core access and b_req in the same cycle, same bank, same in-bank word, and at least one side writing; non-conflicting accesses SHALL both proceed in the same cycle.
REQ-007 On conflict with starve_cnt < STARVE_MAX, the core SHALL win, b_ack SHALL stay 0, and starve_cnt SHALL increment.
REQ-008 On conflict with starve_cnt == STARVE_MAX, port B SHALL win, stall_MEM SHALL be 1 for that cycle, the core access SHALL not execute, and the MEMWB stage SHALL receive a bubble (reg_wr_en_MEMWB=0, fault_MEMWB=0).
REQ-009 b_ack SHALL pulse 1 in every cycle a port B access executes; starve_cnt SHALL clear to 0 on b_ack.
REQ-010 b_rvalid SHALL assert exactly one cycle after a b_ack with b_we==0, with b_rdata holding that word.
REQ-011 stall_MEM SHALL be combinational from current inputs and starve_cnt; only one stall cycle SHALL occur per starvation episode.
REQ-012 Arbiter states SHALL be IDLE (starve_cnt==0), DEFER (0<starve_cnt<STARVE_MAX), and FORCE (starve_cnt==STARVE_MAX). Transitions:
- IDLE to DEFER on conflict.
- DEFER to FORCE on conflict at STARVE_MAX-1.
- Any state to IDLE on b_ack.
- Deassertion of b_req without ack SHALL also return to IDLE.

Reset
REQ-013 While reset is 0, all *_MEMWB outputs, stall_MEM, b_ack, b_rvalid, b_rdata, fault_MEMWB, and starve_cnt SHALL be 0, and no bank write SHALL occur; bank contents SHALL be preserved.
REQ-014 Reset asserted mid-starvation SHALL discard the pending port B request; port B must re-request.

Configuration
REQ-015 Macro MEM_MISALIGN_TRAP_EN, when defined:
- SH with offset[0]=1, or SW with offset!=0, SHALL suppress the write and set fault_MEMWB=1 for one cycle.
- Misaligned loads SHALL set fault_MEMWB=1 and return ld_data_MEMWB=0.
REQ-016 When MEM_MISALIGN_TRAP_EN is undefined, fault_MEMWB SHALL be tied 0, and misaligned halfword/word accesses SHALL ignore the low offset bits that violate alignment.

Structure
REQ-017 Package mem_pkg SHALL hold funct3 load/store encodings, the arbiter state enum, and a bank/index split function.
REQ-018 Sub-module bank_ram SHALL be a true dual-port BRAM with byte write enables and registered read, instantiated NUM_BANKS times via generate.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- SB 0xA5 to address 0x103, then LB of 0x103: ld_data_MEMWB=0xFFFFFFA5. LBU of 0x103: 0x000000A5.
- Core SW to bank 1 word 3, with port B reading bank 2 in the same cycle: both execute, b_ack=1, b_rvalid=1 next cycle.
- Core SW repeated to the same word that port B writes, STARVE_MAX=4: b_ack=0 for cycles 1-4; cycle 5 gives stall_MEM=1, b_ack=1, bubble in MEMWB; starve_cnt returns to 0.
- Reset pulled low during DEFER with starve_cnt=2: all outputs 0 immediately, starve_cnt=0; memory retains prior SW data.
- MEM_MISALIGN_TRAP_EN defined, SW to 0x102: no write (later LW of 0x100 unchanged), fault_MEMWB=1 for one cycle.
- MEM_MISALIGN_TRAP_EN undefined, same SW: fault_MEMWB=0 and the word at 0x100 is written.
